// File: rtl/fpu_queue_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : fpu_queue_dispatcher
// Purpose  : Sequencer between the FPU outer instruction queue and the FPU
//            execution core. Takes the queue head in order, fetches any
//            memory operand as a run of 16-bit word reads, assembles it into
//            an 80-bit buffer, issues the instruction and waits for the core
//            to report completion before looking at the next head.
// Ports    :
//   clk, reset_n        clock, asynchronous active-low reset
//   flush               synchronous abort, returns to IDLE, clears bus_error
//   q_*                 queue head fields / empty flag; q_dequeue pops head
//   mem_req/addr/ack/   16-bit read port; request held until ack
//   mem_rdata
//   exec_*              latched instruction fields, issue strobe, done pulse
//   busy                dispatcher not idle
//   bus_error           sticky fetch watchdog expiry
// Revision : 1.0 - initial release
// ============================================================================
module fpu_queue_dispatcher #(
  parameter int ADDR_WIDTH     = 20,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  q_empty,
  input  logic [7:0]            q_opcode,
  input  logic [2:0]            q_stack_index,
  input  logic [ADDR_WIDTH-1:0] q_ea,
  input  logic [1:0]            q_operand_size,
  input  logic                  q_is_integer,
  input  logic                  q_is_bcd,
  input  logic                  q_has_memory_op,
  input  logic                  q_has_pop,
  output logic                  q_dequeue,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [15:0]           mem_rdata,
  output logic                  exec_start,
  output logic [7:0]            exec_opcode,
  output logic [2:0]            exec_stack_index,
  output logic [1:0]            exec_operand_size,
  output logic                  exec_is_integer,
  output logic                  exec_is_bcd,
  output logic                  exec_has_pop,
  output logic [79:0]           exec_operand,
  input  logic                  exec_done,
  output logic                  busy,
  output logic                  bus_error
);

  // Timer only has to count up to TIMEOUT_CYCLES-1.
  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMER_W-1:0] TIMER_LAST =
    TIMER_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_EXEC  = 3'd3,
    S_DROP  = 3'd4
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] ea_latched;
  logic [2:0]            word_cnt;
  logic [TIMER_W-1:0]    timer;
  logic [2:0]            words_last;
  logic                  last_word;
  logic                  timeout_hit;

  // Index of the final word for each operand size: 1, 2, 4 or 5 words.
  always_comb begin
    words_last = 3'd0;
    case (exec_operand_size)
      2'd0:    words_last = 3'd0;
      2'd1:    words_last = 3'd1;
      2'd2:    words_last = 3'd3;
      default: words_last = 3'd4;
    endcase
  end

  assign last_word   = (word_cnt == words_last);
  assign timeout_hit = TIMEOUT_EN && !mem_ack && (timer == TIMER_LAST);

  // Word address advances by 2 per 16-bit word and wraps at 2^ADDR_WIDTH.
  assign mem_addr = ea_latched + ADDR_WIDTH'({word_cnt, 1'b0});
  assign busy     = (state != S_IDLE);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and strobe decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    exec_start = 1'b0;
    q_dequeue  = 1'b0;
    mem_req    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!q_empty) begin
          state_next = q_has_memory_op ? S_FETCH : S_ISSUE;
        end
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          if (last_word) begin
            state_next = S_ISSUE;
          end
        end else if (timeout_hit) begin
          state_next = S_DROP;
        end
      end
      S_ISSUE: begin
        exec_start = 1'b1;
        q_dequeue  = 1'b1;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        if (exec_done) begin
          state_next = S_IDLE;
        end
      end
      S_DROP: begin
        q_dequeue  = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    // Flush overrides everything, including strobes already decoded above.
    if (flush) begin
      state_next = S_IDLE;
      exec_start = 1'b0;
      q_dequeue  = 1'b0;
      mem_req    = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: head latch, operand assembly, fetch counters, sticky error
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ea_latched        <= '0;
      word_cnt          <= 3'd0;
      timer             <= '0;
      bus_error         <= 1'b0;
      exec_opcode       <= 8'd0;
      exec_stack_index  <= 3'd0;
      exec_operand_size <= 2'd0;
      exec_is_integer   <= 1'b0;
      exec_is_bcd       <= 1'b0;
      exec_has_pop      <= 1'b0;
      exec_operand      <= 80'd0;
    end else if (flush) begin
      word_cnt  <= 3'd0;
      timer     <= '0;
      bus_error <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!q_empty) begin
            ea_latched        <= q_ea;
            exec_opcode       <= q_opcode;
            exec_stack_index  <= q_stack_index;
            exec_operand_size <= q_operand_size;
            exec_is_integer   <= q_is_integer;
            exec_is_bcd       <= q_is_bcd;
            exec_has_pop      <= q_has_pop;
            exec_operand      <= 80'd0;
            word_cnt          <= 3'd0;
            timer             <= '0;
          end
        end
        S_FETCH: begin
          if (mem_ack) begin
            for (int i = 0; i < 5; i++) begin
              if (word_cnt == 3'(i)) begin
                exec_operand[16*i +: 16] <= mem_rdata;
              end
            end
            word_cnt <= word_cnt + 3'd1;
            timer    <= '0;
          end else if (timeout_hit) begin
            bus_error <= 1'b1;
            timer     <= '0;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_queue_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_queue_dispatcher
// Purpose  : Scoreboard bench for fpu_queue_dispatcher. Stimulus pushes queue
//            entries plus expected issue records and read addresses; a queue
//            model, memory responder and core responder react to the DUT,
//            and a monitor compares every issue against the scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_queue_dispatcher;

  localparam int AW  = 20;
  localparam int TMO = 8;

  logic          clk;
  logic          reset_n;
  logic          flush;
  logic          q_empty;
  logic [7:0]    q_opcode;
  logic [2:0]    q_stack_index;
  logic [AW-1:0] q_ea;
  logic [1:0]    q_operand_size;
  logic          q_is_integer;
  logic          q_is_bcd;
  logic          q_has_memory_op;
  logic          q_has_pop;
  logic          q_dequeue;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [15:0]   mem_rdata;
  logic          exec_start;
  logic [7:0]    exec_opcode;
  logic [2:0]    exec_stack_index;
  logic [1:0]    exec_operand_size;
  logic          exec_is_integer;
  logic          exec_is_bcd;
  logic          exec_has_pop;
  logic [79:0]   exec_operand;
  logic          exec_done;
  logic          busy;
  logic          bus_error;

  fpu_queue_dispatcher #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .flush             (flush),
    .q_empty           (q_empty),
    .q_opcode          (q_opcode),
    .q_stack_index     (q_stack_index),
    .q_ea              (q_ea),
    .q_operand_size    (q_operand_size),
    .q_is_integer      (q_is_integer),
    .q_is_bcd          (q_is_bcd),
    .q_has_memory_op   (q_has_memory_op),
    .q_has_pop         (q_has_pop),
    .q_dequeue         (q_dequeue),
    .mem_req           (mem_req),
    .mem_addr          (mem_addr),
    .mem_ack           (mem_ack),
    .mem_rdata         (mem_rdata),
    .exec_start        (exec_start),
    .exec_opcode       (exec_opcode),
    .exec_stack_index  (exec_stack_index),
    .exec_operand_size (exec_operand_size),
    .exec_is_integer   (exec_is_integer),
    .exec_is_bcd       (exec_is_bcd),
    .exec_has_pop      (exec_has_pop),
    .exec_operand      (exec_operand),
    .exec_done         (exec_done),
    .busy              (busy),
    .bus_error         (bus_error)
  );

  typedef struct packed {
    logic [7:0]    opcode;
    logic [2:0]    sidx;
    logic [AW-1:0] ea;
    logic [1:0]    size;
    logic          is_int;
    logic          is_bcd;
    logic          has_mem;
    logic          has_pop;
  } entry_t;

  // Same field order as the monitored exec_* concatenation.
  typedef struct packed {
    logic [7:0]  opcode;
    logic [2:0]  sidx;
    logic [1:0]  size;
    logic        is_int;
    logic        is_bcd;
    logic        has_pop;
    logic [79:0] operand;
  } exp_t;

  entry_t        qm[$];
  exp_t          exp_q[$];
  logic [AW-1:0] addr_q[$];
  logic [15:0]   mem[logic [AW-1:0]];

  int checks    = 0;
  int errors    = 0;
  int starts    = 0;
  int deqs      = 0;
  int ack_total = 0;
  int ack_budget = 1000;
  bit gap       = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive_head();
    if (qm.size() == 0) begin
      q_empty = 1'b1; q_opcode = 8'd0; q_stack_index = 3'd0; q_ea = '0;
      q_operand_size = 2'd0; q_is_integer = 1'b0; q_is_bcd = 1'b0;
      q_has_memory_op = 1'b0; q_has_pop = 1'b0;
    end else begin
      q_empty = 1'b0; q_opcode = qm[0].opcode; q_stack_index = qm[0].sidx;
      q_ea = qm[0].ea; q_operand_size = qm[0].size; q_is_integer = qm[0].is_int;
      q_is_bcd = qm[0].is_bcd; q_has_memory_op = qm[0].has_mem;
      q_has_pop = qm[0].has_pop;
    end
  endtask

  task automatic push_entry(input logic [7:0] op, input logic [2:0] si, input logic [AW-1:0] ea,
                            input logic [1:0] sz, input logic ii, input logic bcd,
                            input logic mop, input logic pop);
    entry_t e;
    e.opcode = op; e.sidx = si; e.ea = ea; e.size = sz;
    e.is_int = ii; e.is_bcd = bcd; e.has_mem = mop; e.has_pop = pop;
    qm.push_back(e);
    drive_head();
  endtask

  task automatic expect_issue(input logic [7:0] op, input logic [2:0] si, input logic [1:0] sz,
                              input logic ii, input logic bcd, input logic pop,
                              input logic [79:0] operand);
    exp_t x;
    x.opcode = op; x.sidx = si; x.size = sz; x.is_int = ii;
    x.is_bcd = bcd; x.has_pop = pop; x.operand = operand;
    exp_q.push_back(x);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0 || qm.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  // Queue model: pop on dequeue, present the new head for the rest of the cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q_dequeue && qm.size() > 0) void'(qm.pop_front());
      drive_head();
    end
  end

  // Memory responder: acks in the same cycle it sees mem_req (optionally every
  // other cycle), checking each acknowledged address against the scoreboard.
  initial begin
    bit phase = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (ack_budget > 0 && !(gap && phase)) begin
          if (addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_addr_unexpected: actual=%0h required=none", mem_addr);
          end else begin
            check("mem_addr", mem_addr, addr_q.pop_front());
          end
          mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 16'hBAD0;
          mem_ack   = 1'b1;
          ack_budget--;
          ack_total++;
        end
        phase = ~phase;
      end else begin
        phase = 1'b0;
      end
    end
  end

  // Core responder: exec_done three cycles after each exec_start.
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      exec_done = 1'b0;
      if (exec_start) begin
        cnt = 3;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) exec_done = 1'b1;
      end
    end
  end

  // Monitor: compares each issue with the scoreboard head and checks that the
  // issued fields stay stable until completion.
  initial begin
    bit   inflight = 1'b0;
    exp_t last;
    exp_t cur;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        cur = {exec_opcode, exec_stack_index, exec_operand_size, exec_is_integer,
               exec_is_bcd, exec_has_pop, exec_operand};
        if (exec_start) begin
          check("issue_with_dequeue", q_dequeue, 1'b1);
          check("issue_after_done", inflight, 1'b0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_issue: actual opcode=%0h required=no issue", exec_opcode);
          end else begin
            check("issue_fields", cur, exp_q.pop_front());
          end
          last     = cur;
          inflight = 1'b1;
          starts++;
        end else if (inflight) begin
          check("exec_stable", cur, last);
          if (exec_done) inflight = 1'b0;
        end
        if (q_dequeue) deqs++;
      end
    end
  end

  initial begin
    int n;
    int cnt;
    int s0;
    int d0;
    int a0;
    reset_n = 1'b0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = 16'd0; exec_done = 1'b0;
    drive_head();
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {q_dequeue, mem_req, mem_addr, exec_start, exec_opcode, exec_stack_index,
           exec_operand_size, exec_is_integer, exec_is_bcd, exec_has_pop,
           exec_operand, busy, bus_error}, 128'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // 1: register op, issue one cycle after head is seen, busy start..done.
    @(posedge clk); #1;
    push_entry(8'hD8, 3'd1, 20'h00000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_issue(8'hD8, 3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 80'd0);
    @(posedge clk); @(negedge clk);
    check("t1_start_latency", {exec_start, q_dequeue}, 2'b11);
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("t1_busy_cycles", n, 4);

    // 2: 64-bit load, four back-to-back acks.
    mem[20'h01000] = 16'h1111; mem[20'h01002] = 16'h2222;
    mem[20'h01004] = 16'h3333; mem[20'h01006] = 16'h4444;
    addr_q.push_back(20'h01000); addr_q.push_back(20'h01002);
    addr_q.push_back(20'h01004); addr_q.push_back(20'h01006);
    @(posedge clk); #1;
    push_entry(8'hDD, 3'd0, 20'h01000, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_issue(8'hDD, 3'd0, 2'd2, 1'b0, 1'b0, 1'b0, 80'h0000_4444_3333_2222_1111);
    wait_idle(100, "t2_idle");

    // 3: 80-bit load across the address wrap, acks every other cycle.
    mem[20'hFFFFC] = 16'hAAAA; mem[20'hFFFFE] = 16'hBBBB; mem[20'h00000] = 16'hCCCC;
    mem[20'h00002] = 16'hDDDD; mem[20'h00004] = 16'hEEEE;
    addr_q.push_back(20'hFFFFC); addr_q.push_back(20'hFFFFE); addr_q.push_back(20'h00000);
    addr_q.push_back(20'h00002); addr_q.push_back(20'h00004);
    gap = 1'b1;
    @(posedge clk); #1;
    push_entry(8'hDB, 3'd5, 20'hFFFFC, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1);
    expect_issue(8'hDB, 3'd5, 2'd3, 1'b0, 1'b1, 1'b1, 80'hEEEE_DDDD_CCCC_BBBB_AAAA);
    wait_idle(100, "t3_idle");
    gap = 1'b0;

    // 4: no ack -> watchdog after 8 cycles, one dequeue, no issue.
    ack_budget = 0;
    s0 = starts; d0 = deqs;
    @(posedge clk); #1;
    push_entry(8'hD9, 3'd2, 20'h00300, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (!mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    cnt = 0;
    while (!bus_error && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    check("t4_timeout_cycles", cnt, 8);
    check("t4_drop_strobes", {q_dequeue, exec_start}, 2'b10);
    wait_idle(50, "t4_idle");
    check("t4_single_dequeue", deqs - d0, 1);
    check("t4_no_issue", starts - s0, 0);
    check("t4_bus_error_sticky", bus_error, 1'b1);

    // 5: flush after the first of two words.
    ack_budget = 1; a0 = ack_total; d0 = deqs;
    mem[20'h00200] = 16'h5A5A;
    addr_q.push_back(20'h00200);
    @(posedge clk); #1;
    push_entry(8'hDC, 3'd3, 20'h00200, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (ack_total == a0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    check("t5_bus_error_before_flush", {bus_error, busy}, 2'b11);
    flush = 1'b1;
    qm.delete();
    drive_head();
    @(posedge clk); #1;
    flush = 1'b0;
    check("t5_after_flush", {busy, mem_req, q_dequeue, exec_start, bus_error}, 5'd0);
    repeat (3) @(negedge clk);
    check("t5_no_dequeue", deqs - d0, 0);
    ack_budget = 1000;

    // 6: three register ops plus a 16-bit load, queued together.
    s0 = starts;
    mem[20'h00010] = 16'h7E57;
    addr_q.push_back(20'h00010);
    @(posedge clk); #1;
    push_entry(8'hD9, 3'd2, 20'h00000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    push_entry(8'hDE, 3'd3, 20'h00000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    push_entry(8'hDA, 3'd4, 20'h00000, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    push_entry(8'hDF, 3'd6, 20'h00010, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_issue(8'hD9, 3'd2, 2'd0, 1'b1, 1'b0, 1'b0, 80'd0);
    expect_issue(8'hDE, 3'd3, 2'd0, 1'b0, 1'b0, 1'b1, 80'd0);
    expect_issue(8'hDA, 3'd4, 2'd1, 1'b0, 1'b0, 1'b0, 80'd0);
    expect_issue(8'hDF, 3'd6, 2'd0, 1'b1, 1'b0, 1'b0, 80'h7E57);
    wait_idle(200, "t6_idle");
    check("t6_issue_count", starts - s0, 4);

    repeat (2) @(negedge clk);
    check("scoreboards_empty", {exp_q.size(), addr_q.size()}, 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
